// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: opcodes, conditions, sizes, immediate types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Instruction layout: [31:27] opcode, [26:25] size/immediate type, [24] sign,
// [23 -: REG_INDEX_WIDTH] register index, [15:12] condition, [IMM_WIDTH-1:0] immediate.
package writeback_stage_pkg;

  typedef enum logic [4:0] {
    OPCODE_NOP    = 5'h00,
    OPCODE_LOAD   = 5'h01,
    OPCODE_LOADI  = 5'h02,
    OPCODE_STORE  = 5'h03,
    OPCODE_ALU    = 5'h04,
    OPCODE_ALUM   = 5'h05,
    OPCODE_ALUMI  = 5'h06,
    OPCODE_BRANCH = 5'h07,
    OPCODE_JUMP   = 5'h08
  } t_opcode;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,  COND_EQ = 4'd1,  COND_NE = 4'd2,  COND_CS = 4'd3,
    COND_CC = 4'd4,  COND_MI = 4'd5,  COND_PL = 4'd6,  COND_VS = 4'd7,
    COND_VC = 4'd8,  COND_HI = 4'd9,  COND_LS = 4'd10, COND_GE = 4'd11,
    COND_LT = 4'd12, COND_GT = 4'd13, COND_LE = 4'd14
  } t_alu_condition;

  // Load access sizes carried in [26:25]
  localparam logic [1:0] CW_BYTE = 2'd0;
  localparam logic [1:0] CW_WORD = 2'd1;
  localparam logic [1:0] CW_LONG = 2'd2;

  typedef enum logic [1:0] {
    IT_UNSIGNED = 2'd0,
    IT_SIGNED   = 2'd1,
    IT_HIGH     = 2'd2,
    IT_LOW      = 2'd3
  } t_immediate_type;

  // Packs to {carry, zero, neg, over}
  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic over;
  } t_flags;

  localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

endpackage

// File: rtl/writeback_stage_if.sv
// Bundles the writeback stage's inbound handshake, ALU inputs and register-file outputs.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carried as ordinary signals.
// Modports: slave = the stage itself, master = the surrounding pipeline / bench.
interface writeback_stage_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 4,
  parameter int IMM_WIDTH       = 16
);
  import writeback_stage_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                inbound_instruction;
  logic [DATA_WIDTH-1:0]      data_in;
  logic [DATA_WIDTH-1:0]      alu_result;
  logic                       alu_carry_out;
  logic                       alu_zero_out;
  logic                       alu_neg_out;
  logic                       alu_over_out;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                outbound_instruction;
  logic                       write;
  logic [REG_INDEX_WIDTH-1:0] write_index;
  logic [DATA_WIDTH-1:0]      write_data;
  logic                       write_immediate;
  logic [IMM_WIDTH-1:0]       write_immediate_data;
  t_immediate_type            write_immediate_type;
  logic                       alu_cycle;
  logic [DATA_WIDTH-1:0]      alu_result_latched;
  logic                       alu_carry_in;
  logic                       jump;
  logic [3:0]                 flags;

  modport slave (
    input  in_valid, inbound_instruction, data_in, alu_result,
           alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out, out_ready,
    output in_ready, out_valid, outbound_instruction, write, write_index, write_data,
           write_immediate, write_immediate_data, write_immediate_type,
           alu_cycle, alu_result_latched, alu_carry_in, jump, flags
  );

  modport master (
    output in_valid, inbound_instruction, data_in, alu_result,
           alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out, out_ready,
    input  in_ready, out_valid, outbound_instruction, write, write_index, write_data,
           write_immediate, write_immediate_data, write_immediate_type,
           alu_cycle, alu_result_latched, alu_carry_in, jump, flags
  );

endinterface

// File: rtl/writeback_stage_cond_eval.sv
// Evaluates a 4-bit condition code against held {carry, zero, neg, over} flags.
// Latency: combinational.
// Backpressure: none.
// Ports: flags (held flags), condition (code), cond_true (result; undefined codes give 0).
module cond_eval
  import writeback_stage_pkg::*;
(
  input  t_flags     flags,
  input  logic [3:0] condition,
  output logic       cond_true
);

  logic n_xor_v;
  assign n_xor_v = flags.neg ^ flags.over;

  always_comb begin
    cond_true = 1'b0;
    case (condition)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = flags.zero;
      COND_NE: cond_true = ~flags.zero;
      COND_CS: cond_true = flags.carry;
      COND_CC: cond_true = ~flags.carry;
      COND_MI: cond_true = flags.neg;
      COND_PL: cond_true = ~flags.neg;
      COND_VS: cond_true = flags.over;
      COND_VC: cond_true = ~flags.over;
      COND_HI: cond_true = flags.carry & ~flags.zero;
      COND_LS: cond_true = ~flags.carry | flags.zero;
      COND_GE: cond_true = ~n_xor_v;
      COND_LT: cond_true = n_xor_v;
      COND_GT: cond_true = ~flags.zero & ~n_xor_v;
      COND_LE: cond_true = flags.zero | n_xor_v;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: decodes each accepted instruction into register writes, flag updates and jumps.
// Latency: 1 cycle from accept to every output; strobes last exactly one cycle.
// Backpressure: in_ready = ~out_valid | out_ready; a stall holds outbound_instruction, never strobes.
// Ports: clock, reset (async active-low), bus (writeback_stage_if.slave: inbound handshake,
// ALU inputs, outbound handshake, register-file strobes, latched ALU result and flags).
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 4,
  parameter int IMM_WIDTH       = 16,
  parameter int SHADOW_SLOTS    = 2
) (
  input logic              clock,
  input logic              reset,
  writeback_stage_if.slave bus
);

  localparam int SQ_W = (SHADOW_SLOTS > 0) ? $clog2(SHADOW_SLOTS + 1) : 1;

  logic [31:0]                instr;
  logic [4:0]                 opcode;
  logic                       accept;
  logic                       cond_true;
  logic                       squashing;
  logic [DATA_WIDTH-1:0]      load_data;

  logic                       out_valid_q;
  logic [31:0]                outbound_q;
  logic                       write_q;
  logic [REG_INDEX_WIDTH-1:0] write_index_q;
  logic [DATA_WIDTH-1:0]      write_data_q;
  logic                       write_imm_q;
  logic [IMM_WIDTH-1:0]       imm_data_q;
  t_immediate_type            imm_type_q;
  logic                       alu_cycle_q;
  logic [DATA_WIDTH-1:0]      result_q;
  logic                       carry_in_q;
  logic                       jump_q;
  t_flags                     flags_q;
  logic [SQ_W-1:0]            squash_cnt;

  assign instr     = bus.inbound_instruction;
  assign opcode    = instr[31:27];
  assign accept    = bus.in_valid & bus.in_ready;
  assign squashing = (squash_cnt != '0);

  // Condition sees flags as held before this instruction: no same-cycle forwarding.
  cond_eval u_cond_eval (
    .flags     (flags_q),
    .condition (instr[15:12]),
    .cond_true (cond_true)
  );

  always_comb begin
    load_data = bus.data_in;
    case (instr[26:25])
      CW_BYTE: load_data = {{(DATA_WIDTH-8){instr[24] & bus.data_in[7]}}, bus.data_in[7:0]};
      CW_WORD: load_data = {{(DATA_WIDTH-16){instr[24] & bus.data_in[15]}}, bus.data_in[15:0]};
      default: load_data = bus.data_in;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      outbound_q    <= NOP_INSTRUCTION;
      write_q       <= 1'b0;
      write_index_q <= '0;
      write_data_q  <= '0;
      write_imm_q   <= 1'b0;
      imm_data_q    <= '0;
      imm_type_q    <= IT_UNSIGNED;
      alu_cycle_q   <= 1'b0;
      result_q      <= '0;
      carry_in_q    <= 1'b0;
      jump_q        <= 1'b0;
      flags_q       <= '0;
      squash_cnt    <= '0;
    end else begin
      // Strobes default low so a stall can never stretch them.
      write_q     <= 1'b0;
      write_imm_q <= 1'b0;
      alu_cycle_q <= 1'b0;
      jump_q      <= 1'b0;
      if (accept) begin
        out_valid_q <= 1'b1;
        if (squashing) begin
          // Shadow slot of a taken jump: forward a bubble, touch nothing else.
          outbound_q <= NOP_INSTRUCTION;
          squash_cnt <= squash_cnt - SQ_W'(1);
        end else begin
          outbound_q <= instr;
          case (opcode)
            OPCODE_LOAD: begin
              write_q       <= 1'b1;
              write_index_q <= instr[23 -: REG_INDEX_WIDTH];
              write_data_q  <= load_data;
            end
            OPCODE_LOADI: begin
              write_imm_q   <= 1'b1;
              write_index_q <= instr[23 -: REG_INDEX_WIDTH];
              imm_data_q    <= instr[IMM_WIDTH-1:0];
              imm_type_q    <= t_immediate_type'(instr[26:25]);
            end
            OPCODE_ALU, OPCODE_ALUM, OPCODE_ALUMI: begin
              flags_q       <= '{carry: bus.alu_carry_out, zero: bus.alu_zero_out,
                                 neg: bus.alu_neg_out, over: bus.alu_over_out};
              carry_in_q    <= bus.alu_carry_out;
              result_q      <= bus.alu_result;
              alu_cycle_q   <= 1'b1;
              write_q       <= 1'b1;
              write_index_q <= instr[23 -: REG_INDEX_WIDTH];
              write_data_q  <= bus.alu_result;
            end
            OPCODE_BRANCH: begin
              if (cond_true) begin
                alu_cycle_q <= 1'b1;
                result_q    <= bus.alu_result;
                jump_q      <= 1'b1;
                squash_cnt  <= SQ_W'(SHADOW_SLOTS);
              end
            end
            OPCODE_JUMP: begin
              if (cond_true) begin
                jump_q     <= 1'b1;
                squash_cnt <= SQ_W'(SHADOW_SLOTS);
              end
            end
            default: ;
          endcase
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready             = ~out_valid_q | bus.out_ready;
  assign bus.out_valid            = out_valid_q;
  assign bus.outbound_instruction = outbound_q;
  assign bus.write                = write_q;
  assign bus.write_index          = write_index_q;
  assign bus.write_data           = write_data_q;
  assign bus.write_immediate      = write_imm_q;
  assign bus.write_immediate_data = imm_data_q;
  assign bus.write_immediate_type = imm_type_q;
  assign bus.alu_cycle            = alu_cycle_q;
  assign bus.alu_result_latched   = result_q;
  assign bus.alu_carry_in         = carry_in_q;
  assign bus.jump                 = jump_q;
  assign bus.flags                = flags_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int IW = 16;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  writeback_stage_if #(.DATA_WIDTH(DW), .REG_INDEX_WIDTH(RW), .IMM_WIDTH(IW)) bus ();

  writeback_stage #(.DATA_WIDTH(DW), .REG_INDEX_WIDTH(RW), .IMM_WIDTH(IW), .SHADOW_SLOTS(SS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] f, input logic s,
                                     input logic [3:0] idx, input logic [15:0] low);
    return {op, f, s, idx, 4'h0, low};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] d,
                       input logic [31:0] a, input logic [3:0] fl);
    bus.in_valid            = v;
    bus.inbound_instruction = ins;
    bus.data_in             = d;
    bus.alu_result          = a;
    {bus.alu_carry_out, bus.alu_zero_out, bus.alu_neg_out, bus.alu_over_out} = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Condition truth from the flag rules, indexed by condition code.
  function automatic bit cond_ok(input logic [3:0] code, input logic [3:0] f);
    bit c, z, n, v;
    bit [15:0] t;
    c = f[3]; z = f[2]; n = f[1]; v = f[0];
    t = {1'b0, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
         ~v, v, ~n, n, ~c, c, ~z, z, 1'b1};
    return t[code];
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] d;
    logic [31:0] a;
    logic [3:0]  fl;
    logic        e_write;
    logic        e_chk_wd;
    logic [31:0] e_wd;
    logic        e_wimm;
    logic [15:0] e_imm;
    logic        e_alu;
    logic        e_jump;
    logic [3:0]  e_flags;
    logic        e_nop;
  } vec_t;

  vec_t tbl[15];

  // Reference model state
  logic        m_ov;
  logic [31:0] m_out;
  logic        m_w, m_wi, m_ac, m_j, m_chkwd, m_cin;
  logic [3:0]  m_idx, m_fl;
  logic [31:0] m_wd, m_res;
  logic [15:0] m_imm;
  logic [1:0]  m_it;
  int          m_sq;

  logic [4:0] ops[9];

  initial begin
    logic [31:0] ins;
    logic [31:0] rd, ra;
    logic [3:0]  rfl;
    logic        rv, rr, exp_ir;

    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);

    // ---- 1: reset state ----
    do_reset();
    tick();
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst outbound", bus.outbound_instruction, NOP_INSTRUCTION);
    chk("rst strobes", {bus.write, bus.write_immediate, bus.alu_cycle, bus.jump}, 0);
    chk("rst flags", bus.flags, 0);
    chk("rst carry_in", bus.alu_carry_in, 0);
    chk("rst imm_type", bus.write_immediate_type, IT_UNSIGNED);
    chk("rst latched", bus.alu_result_latched, 0);
    chk("rst in_ready", bus.in_ready, 1);

    // ---- table-driven single-issue sequence ----
    tbl[0]  = '{mk(OPCODE_LOAD, CW_BYTE, 1'b1, 4'h1, 16'h0), 32'h000000F0, 32'h0, 4'h0,
                1'b1, 1'b1, 32'hFFFFFFF0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{mk(OPCODE_LOAD, CW_BYTE, 1'b0, 4'h2, 16'h0), 32'h000000F0, 32'h0, 4'h0,
                1'b1, 1'b1, 32'h000000F0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{mk(OPCODE_LOAD, CW_WORD, 1'b1, 4'h3, 16'h0), 32'hABCD8001, 32'h0, 4'h0,
                1'b1, 1'b1, 32'hFFFF8001, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{mk(OPCODE_LOAD, CW_WORD, 1'b0, 4'h4, 16'h0), 32'h00018001, 32'h0, 4'h0,
                1'b1, 1'b1, 32'h00008001, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[4]  = '{mk(OPCODE_LOAD, CW_LONG, 1'b1, 4'h5, 16'h0), 32'h80000012, 32'h0, 4'h0,
                1'b1, 1'b1, 32'h80000012, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[5]  = '{mk(OPCODE_LOADI, IT_SIGNED, 1'b0, 4'h6, 16'h1234), 32'h0, 32'h0, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b1, 16'h1234, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[6]  = '{mk(OPCODE_ALU, 2'd0, 1'b0, 4'h7, 16'h0), 32'h0, 32'h55, 4'b0100,
                1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b0, 4'b0100, 1'b0};
    tbl[7]  = '{mk(OPCODE_BRANCH, 2'd0, 1'b0, 4'h0, {COND_NE, 12'h0}), 32'h0, 32'h1000, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0100, 1'b0};
    tbl[8]  = '{mk(OPCODE_JUMP, 2'd0, 1'b0, 4'h0, {COND_LT, 12'h0}), 32'h0, 32'h0, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0100, 1'b0};
    tbl[9]  = '{mk(OPCODE_ALUM, 2'd0, 1'b0, 4'h8, 16'h0), 32'h0, 32'h66, 4'b0010,
                1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b0, 4'b0010, 1'b0};
    tbl[10] = '{mk(OPCODE_BRANCH, 2'd0, 1'b0, 4'h0, {COND_LT, 12'h0}), 32'h0, 32'h2000, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b1, 4'b0010, 1'b0};
    tbl[11] = '{mk(OPCODE_LOAD, CW_LONG, 1'b0, 4'h9, 16'h0), 32'h77, 32'h0, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0010, 1'b1};
    tbl[12] = '{mk(OPCODE_ALUMI, 2'd0, 1'b0, 4'hA, 16'h0), 32'h0, 32'h99, 4'b1111,
                1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0010, 1'b1};
    tbl[13] = '{mk(OPCODE_JUMP, 2'd0, 1'b0, 4'h0, {COND_GE, 12'h0}), 32'h0, 32'h0, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0010, 1'b0};
    tbl[14] = '{mk(OPCODE_JUMP, 2'd0, 1'b0, 4'h0, 16'hF000), 32'h0, 32'h0, 4'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0010, 1'b0};

    for (int i = 0; i < 15; i++) begin
      drive(1'b1, tbl[i].ins, tbl[i].d, tbl[i].a, tbl[i].fl);
      tick();
      chk($sformatf("tbl%0d out_valid", i), bus.out_valid, 1);
      chk($sformatf("tbl%0d outbound", i), bus.outbound_instruction,
          tbl[i].e_nop ? NOP_INSTRUCTION : tbl[i].ins);
      chk($sformatf("tbl%0d write", i), bus.write, tbl[i].e_write);
      chk($sformatf("tbl%0d write_imm", i), bus.write_immediate, tbl[i].e_wimm);
      chk($sformatf("tbl%0d alu_cycle", i), bus.alu_cycle, tbl[i].e_alu);
      chk($sformatf("tbl%0d jump", i), bus.jump, tbl[i].e_jump);
      chk($sformatf("tbl%0d flags", i), bus.flags, tbl[i].e_flags);
      if (tbl[i].e_chk_wd) chk($sformatf("tbl%0d write_data", i), bus.write_data, tbl[i].e_wd);
      if (tbl[i].e_wimm) chk($sformatf("tbl%0d imm_data", i), bus.write_immediate_data, tbl[i].e_imm);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("tbl tail out_valid", bus.out_valid, 0);

    // ---- 3: ALU zero then BRANCH EQ / NE ----
    do_reset();
    drive(1'b1, mk(OPCODE_ALU, 2'd0, 1'b0, 4'h1, 16'h0), 32'h0, 32'h7, 4'b0100);
    tick();
    drive(1'b1, mk(OPCODE_BRANCH, 2'd0, 1'b0, 4'h0, {COND_EQ, 12'h0}), 32'h0, 32'h1000, 4'h0);
    tick();
    chk("beq jump", bus.jump, 1);
    chk("beq alu_cycle", bus.alu_cycle, 1);
    chk("beq latched", bus.alu_result_latched, 32'h1000);
    do_reset();
    drive(1'b1, mk(OPCODE_ALU, 2'd0, 1'b0, 4'h1, 16'h0), 32'h0, 32'h7, 4'b0100);
    tick();
    drive(1'b1, mk(OPCODE_BRANCH, 2'd0, 1'b0, 4'h0, {COND_NE, 12'h0}), 32'h0, 32'h1000, 4'h0);
    tick();
    chk("bne jump", bus.jump, 0);
    chk("bne alu_cycle", bus.alu_cycle, 0);
    chk("bne latched", bus.alu_result_latched, 32'h7);

    // ---- 4: JUMP HI taken, two shadow LOADs squashed ----
    do_reset();
    drive(1'b1, mk(OPCODE_ALU, 2'd0, 1'b0, 4'h1, 16'h0), 32'h0, 32'h1, 4'b1000);
    tick();
    drive(1'b1, mk(OPCODE_JUMP, 2'd0, 1'b0, 4'h0, {COND_HI, 12'h0}), 32'h0, 32'h0, 4'h0);
    tick();
    chk("jhi jump", bus.jump, 1);
    for (int k = 0; k < 3; k++) begin
      ins = mk(OPCODE_LOAD, CW_LONG, 1'b0, 4'(k + 2), 16'h0);
      drive(1'b1, ins, 32'hCAFE0000 + 32'(k), 32'h0, 4'h0);
      tick();
      chk($sformatf("shadow%0d write", k), bus.write, (k == 2) ? 1 : 0);
      chk($sformatf("shadow%0d outbound", k), bus.outbound_instruction,
          (k == 2) ? ins : NOP_INSTRUCTION);
      chk($sformatf("shadow%0d out_valid", k), bus.out_valid, 1);
    end
    chk("shadow2 write_data", bus.write_data, 32'hCAFE0002);

    // ---- 5: stall after LOADI ----
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, mk(OPCODE_LOADI, IT_HIGH, 1'b0, 4'h3, 16'h1234), 32'h0, 32'h0, 4'h0);
    tick();
    ins = mk(OPCODE_LOAD, CW_BYTE, 1'b0, 4'h4, 16'h0);
    drive(1'b1, ins, 32'h000000AB, 32'h0, 4'h0);
    #1;
    chk("stall wimm first", bus.write_immediate, 1);
    chk("stall imm data", bus.write_immediate_data, 16'h1234);
    chk("stall imm type", bus.write_immediate_type, IT_HIGH);
    chk("stall in_ready c1", bus.in_ready, 0);
    for (int k = 2; k <= 3; k++) begin
      tick();
      chk($sformatf("stall c%0d wimm", k), bus.write_immediate, 0);
      chk($sformatf("stall c%0d in_ready", k), bus.in_ready, 0);
      chk($sformatf("stall c%0d outbound", k), bus.outbound_instruction,
          mk(OPCODE_LOADI, IT_HIGH, 1'b0, 4'h3, 16'h1234));
      chk($sformatf("stall c%0d out_valid", k), bus.out_valid, 1);
      chk($sformatf("stall c%0d write", k), bus.write, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", bus.in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    chk("release write", bus.write, 1);
    chk("release outbound", bus.outbound_instruction, ins);
    chk("release write_data", bus.write_data, 32'h000000AB);
    chk("release wimm", bus.write_immediate, 0);
    tick();
    chk("release drain out_valid", bus.out_valid, 0);

    // ---- 6: reset during stall with squash pending ----
    do_reset();
    drive(1'b1, mk(OPCODE_JUMP, 2'd0, 1'b0, 4'h0, {COND_AL, 12'h0}), 32'h0, 32'h0, 4'h0);
    tick();
    drive(1'b1, mk(OPCODE_LOAD, CW_LONG, 1'b0, 4'h1, 16'h0), 32'h11, 32'h0, 4'h0);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("mid out_valid pre", bus.out_valid, 1);
    chk("mid outbound pre", bus.outbound_instruction, NOP_INSTRUCTION);
    reset = 1'b0;
    #2;
    chk("mid async out_valid", bus.out_valid, 0);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("post rst out_valid", bus.out_valid, 0);
    ins = mk(OPCODE_LOAD, CW_BYTE, 1'b0, 4'h2, 16'h0);
    drive(1'b1, ins, 32'h0000005A, 32'h0, 4'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    chk("post rst write", bus.write, 1);
    chk("post rst write_data", bus.write_data, 32'h5A);
    chk("post rst outbound", bus.outbound_instruction, ins);

    // ---- randomized run against the reference model ----
    ops = '{OPCODE_NOP, OPCODE_LOAD, OPCODE_LOADI, OPCODE_ALU, OPCODE_ALUM,
            OPCODE_ALUMI, OPCODE_BRANCH, OPCODE_JUMP, 5'h1F};
    do_reset();
    m_ov = 1'b0; m_out = NOP_INSTRUCTION; m_w = 1'b0; m_wi = 1'b0; m_ac = 1'b0; m_j = 1'b0;
    m_chkwd = 1'b0; m_cin = 1'b0; m_idx = 4'h0; m_fl = 4'h0; m_wd = 32'h0; m_res = 32'h0;
    m_imm = 16'h0; m_it = 2'd0; m_sq = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ins = mk(ops[$urandom_range(0, 8)], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
      rd  = $urandom;
      ra  = $urandom;
      rfl = 4'($urandom_range(0, 15));
      rv  = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      drive(rv, ins, rd, ra, rfl);
      bus.out_ready = rr;
      #1;
      exp_ir = !m_ov || rr;
      chk("rnd in_ready", bus.in_ready, exp_ir);

      m_w = 1'b0; m_wi = 1'b0; m_ac = 1'b0; m_j = 1'b0;
      if (rv && exp_ir) begin
        m_ov = 1'b1;
        if (m_sq > 0) begin
          m_out = NOP_INSTRUCTION;
          m_sq--;
        end else begin
          m_out = ins;
          case (ins[31:27])
            OPCODE_LOAD: begin
              m_w = 1'b1; m_chkwd = 1'b1; m_idx = ins[23:20];
              if (ins[26:25] == CW_BYTE)
                m_wd = (ins[24] && rd[7]) ? {24'hFFFFFF, rd[7:0]} : {24'h0, rd[7:0]};
              else if (ins[26:25] == CW_WORD)
                m_wd = (ins[24] && rd[15]) ? {16'hFFFF, rd[15:0]} : {16'h0, rd[15:0]};
              else
                m_wd = rd;
            end
            OPCODE_LOADI: begin
              m_wi = 1'b1; m_idx = ins[23:20]; m_imm = ins[15:0]; m_it = ins[26:25];
            end
            OPCODE_ALU, OPCODE_ALUM, OPCODE_ALUMI: begin
              m_fl = rfl; m_cin = rfl[3]; m_res = ra; m_ac = 1'b1;
              m_w = 1'b1; m_chkwd = 1'b0; m_idx = ins[23:20];
            end
            OPCODE_BRANCH: if (cond_ok(ins[15:12], m_fl)) begin
              m_ac = 1'b1; m_res = ra; m_j = 1'b1; m_sq = SS;
            end
            OPCODE_JUMP: if (cond_ok(ins[15:12], m_fl)) begin
              m_j = 1'b1; m_sq = SS;
            end
            default: ;
          endcase
        end
      end else if (rr) begin
        m_ov = 1'b0;
      end

      tick();
      chk("rnd out_valid", bus.out_valid, m_ov);
      chk("rnd outbound", bus.outbound_instruction, m_out);
      chk("rnd write", bus.write, m_w);
      chk("rnd write_imm", bus.write_immediate, m_wi);
      chk("rnd alu_cycle", bus.alu_cycle, m_ac);
      chk("rnd jump", bus.jump, m_j);
      chk("rnd flags", bus.flags, m_fl);
      chk("rnd carry_in", bus.alu_carry_in, m_cin);
      chk("rnd latched", bus.alu_result_latched, m_res);
      if (m_w || m_wi) chk("rnd write_index", bus.write_index, m_idx);
      if (m_w && m_chkwd) chk("rnd write_data", bus.write_data, m_wd);
      if (m_wi) begin
        chk("rnd imm_data", bus.write_immediate_data, m_imm);
        chk("rnd imm_type", bus.write_immediate_type, m_it);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Parametrised successor to the pipeline's stage-2 register/flags stage. It sits between the memory/ALU stage and the register file and fetch unit. Per instruction it decodes the opcode, then produces:
- register-file write strobes, with LOAD sign/zero extension and LOADI immediate writes;
- latched ALU flags and the condition test;
- jump strobes.

New over the previous generation: generic data/index widths, a valid/ready handshake with downstream stall, a corrected full condition set, and a shadow-slot squash counter after a taken jump.

Parameters:
DATA_WIDTH, 32, register/ALU data width; must be >= 32.
REG_INDEX_WIDTH, 4, register index width; field is inbound_instruction[23 -: REG_INDEX_WIDTH].
IMM_WIDTH, 16, immediate field width; field is inbound_instruction[IMM_WIDTH-1:0].
SHADOW_SLOTS, 2, instructions squashed after a taken jump/branch; 0 disables squashing.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  inbound_instruction and data are valid
in_ready  out  1  stage can accept; combinational ~out_valid | out_ready
inbound_instruction  in  32  instruction from the previous stage
data_in  in  DATA_WIDTH  memory read data for LOAD
alu_result  in  DATA_WIDTH  ALU result / branch target
alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out  in  1 each  ALU flags
out_valid  out  1  outbound_instruction is valid
out_ready  in  1  downstream accepts outbound_instruction
outbound_instruction  out  32  instruction passed forward (NOP when squashed)
write  out  1  register write strobe
write_index  out  REG_INDEX_WIDTH  destination register
write_data  out  DATA_WIDTH  data for write
write_immediate  out  1  immediate write strobe
write_immediate_data  out  IMM_WIDTH  immediate value
write_immediate_type  out  2  t_immediate_type
alu_cycle  out  1  ALU result committed this cycle
alu_result_latched  out  DATA_WIDTH  latched ALU result / jump target
alu_carry_in  out  1  latched carry for the next ALU op
jump  out  1  taken-jump strobe
flags  out  4  {carry, zero, neg, over} as held

Behaviour:
- Accept occurs when in_valid & in_ready. All outputs are registered and change one cycle after accept.
- Reset (reset=0, async) clears everything:
  - outbound_instruction = {OPCODE_NOP, 27'h0}; out_valid=0.
  - All strobes 0; write_index, write_data, write_immediate_data, alu_result_latched, flags and alu_carry_in all 0.
  - write_immediate_type = IT_UNSIGNED; squash counter = 0.
- Strobes (write, write_immediate, alu_cycle, jump) are high for exactly one cycle after each accept that requires them, otherwise 0. A downstream stall never extends or repeats a strobe.
- Output register handling:
  - On accept: outbound_instruction <= instruction; out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - While out_valid & ~out_ready, outbound_instruction holds.
- LOADI: write_index from the index field; type from [26:25]; data from the immediate field; write_immediate=1.
- LOAD: write=1. Size [26:25], sign flag [24]:
  - CW_BYTE: extend data_in[7:0] (sign- or zero-extend per [24]).
  - CW_WORD: extend data_in[15:0] (sign- or zero-extend per [24]).
  - Otherwise: data_in unchanged.
- ALU, ALUM, ALUMI:
  - flags <= ALU flags; alu_carry_in <= alu_carry_out; alu_result_latched <= alu_result.
  - alu_cycle=1; write=1; write_index from the index field.
- Condition field [15:12] is evaluated combinationally on the held flags (c,z,n,v):
  - AL=1, EQ=z, NE=~z, CS=c, CC=~c, MI=n, PL=~n, VS=v, VC=~v.
  - HI=c&~z, LS=~c|z.
  - GE=~(n^v), LT=n^v, GT=~z&~(n^v), LE=z|(n^v).
  - Any undefined code = 0.
- An ALU op accepted in cycle N updates flags visibly for a branch accepted in cycle N+1 or later (no same-cycle forwarding).
- BRANCH with condition true: alu_cycle=1, alu_result_latched <= alu_result, jump=1.
- JUMP with condition true: jump=1.
- Not-taken branch/jump: no strobes.
- Taken jump/branch loads the squash counter with SHADOW_SLOTS. While the counter is nonzero, each accepted instruction:
  - is forwarded as NOP with out_valid=1;
  - produces no strobes and leaves flags untouched;
  - decrements the counter.
  Only accepts decrement the counter; stalls hold it.
- NOP and other opcodes: passed forward, no strobes.
- Reset asserted mid-stall: the pending output is dropped and the squash counter is cleared.

Decomposition:
- Opcode (t_opcode), condition (t_alu_condition), size (CW_*) and immediate-type (t_immediate_type) definitions come from the shared opcodes/alu/businterface/registers packages. No new constants are local to this block.
- One sub-module, cond_eval: a combinational flags-plus-condition-to-cond_true function, reused by later stages.

Test Plan:
1. Reset then release with no input -> out_valid=0, all strobes 0, outbound_instruction={OPCODE_NOP,27'h0}, flags=0.
2. LOAD CW_BYTE, signed, data_in=32'h000000F0 -> one cycle later write=1, write_data=32'hFFFFFFF0. Repeat unsigned -> 32'h000000F0.
3. ALU op with alu_zero_out=1, then BRANCH EQ next cycle with alu_result=32'h1000 -> jump=1, alu_cycle=1, alu_result_latched=32'h1000. BRANCH NE in the same position -> no jump.
4. Flags c=1,z=0 then JUMP HI -> taken. The next 2 accepted LOADs emit NOP, with write=0. The third LOAD writes normally.
5. out_ready=0 for 3 cycles after accepting LOADI 16'h1234 -> write_immediate high one cycle only; in_ready=0 and outbound_instruction held for 3 cycles; then released.
6. Reset asserted with squash counter=1 and out_valid=1 -> after release, the next LOAD writes (no squash) and out_valid=0 until that accept.
